// File: rtl/nios2_system_timer_master.sv
// Avalon-MM master that programs, services and stops a Nios II interval timer.
// Optional snapshot read-back path enabled by defining TIMER_MASTER_SNAP_EN.
module nios2_system_timer_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] period,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        irq,
  output logic        busy,
  output logic        running,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [31:0] snapshot
);

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PL     = 3'd2;
  localparam logic [2:0] A_PH     = 3'd3;
`ifdef TIMER_MASTER_SNAP_EN
  localparam logic [2:0] A_SNL    = 3'd4;
  localparam logic [2:0] A_SNH    = 3'd5;
`endif

  // ITO | CONT | START, and STOP alone
  localparam logic [15:0] CTRL_GO   = 16'h0007;
  localparam logic [15:0] CTRL_STOP = 16'h0008;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    RUN,
    CLR_TO,
`ifdef TIMER_MASTER_SNAP_EN
    SNAP_WR,
    RD_SL,
    RD_SH,
    CAP_SH,
`endif
    STOP_WR,
    STOP_CLR
  } state_t;

  state_t      state_q;
  logic [2:0]  addr_q;
  logic        cs_q;
  logic        wn_q;
  logic [15:0] wd_q;
  logic        busy_q;
  logic        run_q;
  logic        tick_q;
  logic [31:0] tick_count_q;
  logic [31:0] per_q;

`ifdef TIMER_MASTER_SNAP_EN
  logic [15:0] snap_lo_q;
  logic [31:0] snap_q;
  assign snapshot = snap_q;
`else
  logic unused_rd;
  assign unused_rd = ^avm_readdata;
  assign snapshot  = 32'd0;
`endif

  // The low half is driven straight from the port when start is accepted
  logic unused_lo;
  assign unused_lo = ^per_q[15:0];

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wd_q;
  assign busy           = busy_q;
  assign running        = run_q;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;

  // Sequencer: bus and status outputs are registered for the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= 3'd0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      wd_q         <= 16'h0000;
      busy_q       <= 1'b0;
      run_q        <= 1'b0;
      tick_q       <= 1'b0;
      tick_count_q <= 32'd0;
      per_q        <= 32'd0;
`ifdef TIMER_MASTER_SNAP_EN
      snap_lo_q    <= 16'h0000;
      snap_q       <= 32'd0;
`endif
    end else begin
      addr_q <= 3'd0;
      cs_q   <= 1'b0;
      wn_q   <= 1'b1;
      wd_q   <= 16'h0000;
      tick_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            per_q   <= period;
            state_q <= WR_PL;
            busy_q  <= 1'b1;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            addr_q  <= A_PL;
            wd_q    <= period[15:0];
          end
        end
        WR_PL: begin
          state_q <= WR_PH;
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= A_PH;
          wd_q    <= per_q[31:16];
        end
        WR_PH: begin
          state_q <= WR_CTRL;
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= A_CTRL;
          wd_q    <= CTRL_GO;
        end
        WR_CTRL: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
          run_q   <= 1'b1;
        end
        RUN: begin
          if (stop) begin
            state_q <= STOP_WR;
            busy_q  <= 1'b1;
            run_q   <= 1'b0;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            addr_q  <= A_CTRL;
            wd_q    <= CTRL_STOP;
          end else if (irq) begin
            state_q <= CLR_TO;
            busy_q  <= 1'b1;
            run_q   <= 1'b0;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            addr_q  <= A_STATUS;
            wd_q    <= 16'h0000;
          end
        end
`ifdef TIMER_MASTER_SNAP_EN
        CLR_TO: begin
          state_q <= SNAP_WR;
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= A_SNL;
          wd_q    <= 16'h0000;
        end
        SNAP_WR: begin
          state_q <= RD_SL;
          cs_q    <= 1'b1;
          addr_q  <= A_SNL;
        end
        RD_SL: begin
          state_q <= RD_SH;
          cs_q    <= 1'b1;
          addr_q  <= A_SNH;
        end
        RD_SH: begin
          state_q   <= CAP_SH;
          snap_lo_q <= avm_readdata;
        end
        CAP_SH: begin
          state_q      <= RUN;
          busy_q       <= 1'b0;
          run_q        <= 1'b1;
          tick_q       <= 1'b1;
          tick_count_q <= tick_count_q + 32'd1;
          snap_q       <= {avm_readdata, snap_lo_q};
        end
`else
        CLR_TO: begin
          state_q      <= RUN;
          busy_q       <= 1'b0;
          run_q        <= 1'b1;
          tick_q       <= 1'b1;
          tick_count_q <= tick_count_q + 32'd1;
        end
`endif
        STOP_WR: begin
          state_q <= STOP_CLR;
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= A_STATUS;
          wd_q    <= 16'h0000;
        end
        STOP_CLR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
